ut_bus_datapath: RTL
====================

UT_BUS_DATAPATH -- requirements
Module: ut_bus_datapath

Interface
Parameters:
REQ-001 The block SHALL have parameter XLEN, default 32, giving the datapath width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter NREG, default 4, giving the register-file depth (power of two, 2..32); RAW = $clog2(NREG).
REQ-003 The block SHALL have parameter RESET_PC, default 0, giving the PC value after reset.

Ports:
REQ-004 The block SHALL have these ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- src_imm, src_alu, src_pc, src_rf, src_rd  in  1 each  bus source enables.
- ir_en, a_en, b_en, pc_en  in  1 each  bus-sink load enables.
- pc_inc  in  1  PC += 4.
- rf_wen  in  1  register-file write enable.
- rf_waddr  in  RAW  register-file write address.
- rf_raddr  in  RAW  register-file read address.
- alu_func  in  3  ALU operation.
- imm_type  in  3  immediate format.
- rd_data  in  XLEN  external read data.
- databus  out  XLEN  shared bus value.
- instr  out  32  IR contents.
- pc  out  XLEN  PC register.
- alu_carry, alu_zero  out  1 each  registered ALU flags.
- bus_conflict  out  1  more than one source enable this cycle (combinational).
- bus_err  out  1  sticky conflict flag.

Function
REQ-005 The bus SHALL be combinational, with fixed source priority imm > alu > pc > rf > rd; with no source enabled, databus SHALL be 0 (no latch).
REQ-006 bus_conflict SHALL be 1 whenever two or more src_* enables are high; the priority winner still drives the bus.
REQ-007 bus_err SHALL set on the first clock edge where bus_conflict=1 and hold until reset.
REQ-008 On a clock edge, ir_en SHALL load databus[31:0] into IR, a_en SHALL load the bus into A, and b_en SHALL load the bus into B; these loads are independent and may occur together.
REQ-009 PC update priority SHALL be: pc_en loads databus; otherwise pc_inc sets PC to PC+4 modulo 2^XLEN; otherwise PC holds.
REQ-010 The ALU SHALL compute from A and B combinationally, with alu_func encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 0/1), 6 SLL, 7 SRL (shift amount B[log2(XLEN)-1:0]).
REQ-011 The ALU carry SHALL be the bit XLEN carry-out for ADD, NOT borrow for SUB (1 when A>=B unsigned), and 0 for all other operations.
REQ-012 alu_carry and alu_zero SHALL be registered only on edges where src_alu is the bus winner; alu_zero is 1 when the result is 0; otherwise both hold.
REQ-013 The register file SHALL hold NREG x XLEN registers; register 0 reads 0 and ignores writes.
REQ-014 A write SHALL occur on the edge when rf_wen=1, writing databus to rf_waddr.
REQ-015 The read port SHALL be combinational from rf_raddr; a same-cycle write to the read address returns the old value, and the new value is visible the next cycle.
REQ-016 The immediate generator SHALL decode IR, sign-extended to XLEN, by imm_type: 0 I (IR[31:20]), 1 S ({IR[31:25],IR[11:7]}), 2 B ({IR[31],IR[7],IR[30:25],IR[11:8],0}), 3 U ({IR[31:12],12'b0}), 4 J ({IR[31],IR[19:12],IR[20],IR[30:21],0}); types 5-7 SHALL yield 0.
REQ-017 Load-from-bus SHALL use the bus value of the same cycle, so a source-to-sink transfer completes in one cycle.
REQ-018 instr SHALL equal IR and pc SHALL equal PC.

Reset
REQ-019 While rst=1, asynchronously: PC=RESET_PC; IR, A, B and all RF entries =0; alu_carry=0, alu_zero=0, bus_err=0.
REQ-020 Deasserting rst mid-operation SHALL leave no pending state; the first edge after release behaves as a normal cycle.
REQ-021 Sink enables asserted during reset SHALL have no effect.

Verification
REQ-022 Load test: rd_data=0x12345678, src_rd=1, a_en=1 for 1 cycle -> A=0x12345678 and databus=0x12345678 in that cycle.
REQ-023 ALU/flags test: A=0xFFFFFFFF, B=1, alu_func=0, src_alu=1 -> databus=0, alu_carry=1, alu_zero=1 after the edge; then SUB with A=1, B=2 -> 0xFFFFFFFF, alu_carry=0, alu_zero=0.
REQ-024 Conflict test: src_pc=1 and src_rf=1 in the same cycle -> databus=PC, bus_conflict=1, bus_err=1 from the next edge and still 1 after 100 idle cycles.
REQ-025 PC test: reset, then pc_inc for 3 cycles -> PC=RESET_PC+12; pc_en with bus=0x100 and pc_inc together -> PC=0x100; with XLEN=32 and PC=0xFFFFFFFC, pc_inc -> PC=0.
REQ-026 RF/ImmGen test: rf_wen to reg 0 -> reads 0; write 0xA5 to reg 1, read in the same cycle -> old value, next cycle -> 0xA5; IR=0xFFF00093 with imm_type=0 -> imm=0xFFFFFFFF.
REQ-027 Async reset test: assert rst between clock edges mid-transfer -> all outputs take reset values immediately, before the next edge.

Source files
------------

// File: rtl/ut_bus_datapath.sv
// ut_bus_datapath: single shared-bus datapath with a prioritised source mux,
// IR/A/B/PC sink registers, a small ALU with registered flags, a register
// file and an immediate generator driven from the IR.
module ut_bus_datapath #(
  parameter int XLEN = 32,
  parameter int NREG = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int RAW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            src_imm,
  input  logic            src_alu,
  input  logic            src_pc,
  input  logic            src_rf,
  input  logic            src_rd,
  input  logic            ir_en,
  input  logic            a_en,
  input  logic            b_en,
  input  logic            pc_en,
  input  logic            pc_inc,
  input  logic            rf_wen,
  input  logic [RAW-1:0]  rf_waddr,
  input  logic [RAW-1:0]  rf_raddr,
  input  logic [2:0]      alu_func,
  input  logic [2:0]      imm_type,
  input  logic [XLEN-1:0] rd_data,
  output logic [XLEN-1:0] databus,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic            alu_carry,
  output logic            alu_zero,
  output logic            bus_conflict,
  output logic            bus_err
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [31:0]     ir_q, ir_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];

  logic [XLEN-1:0] imm_val;
  logic [XLEN-1:0] alu_res;
  logic            alu_c;
  logic [XLEN-1:0] rf_rdata;
  logic [4:0]      src_vec;
  logic            alu_wins;

  // Immediate formats are assembled as 32-bit signed values, then the size
  // cast sign-extends them to the datapath width.
  function automatic logic [XLEN-1:0] imm_decode(input logic [31:0] ir,
                                                 input logic [2:0]  typ);
    logic signed [31:0] v;
    case (typ)
      3'd0:    v = {{20{ir[31]}}, ir[31:20]};
      3'd1:    v = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      3'd2:    v = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      3'd3:    v = {ir[31:12], 12'b0};
      3'd4:    v = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: v = '0;
    endcase
    return XLEN'(v);
  endfunction

  // Returns {carry, result}; carry is the adder carry-out for ADD and the
  // inverted borrow (A >= B unsigned) for SUB.
  function automatic logic [XLEN:0] alu_calc(input logic [2:0]      func,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] as;
    logic signed [XLEN-1:0] bs;
    logic [XLEN:0]          sum;
    logic [XLEN-1:0]        r;
    logic                   c;
    as  = a;
    bs  = b;
    sum = '0;
    c   = 1'b0;
    case (func)
      3'd0: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[XLEN-1:0];
        c   = sum[XLEN];
      end
      3'd1: begin
        r = a - b;
        c = (a >= b);
      end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = (as < bs) ? XLEN'(1) : '0;
      3'd6:    r = a << b[SHW-1:0];
      default: r = a >> b[SHW-1:0];
    endcase
    return {c, r};
  endfunction

  assign imm_val   = imm_decode(ir_q, imm_type);
  assign {alu_c, alu_res} = alu_calc(alu_func, a_q, b_q);
  assign rf_rdata  = rf_q[rf_raddr];
  assign src_vec   = {src_imm, src_alu, src_pc, src_rf, src_rd};
  assign alu_wins  = src_alu & ~src_imm;

  // Shared bus: fixed-priority source select, zero when nothing drives it.
  always_comb begin
    databus = '0;
    if (src_imm)     databus = imm_val;
    else if (src_alu) databus = alu_res;
    else if (src_pc)  databus = pc_q;
    else if (src_rf)  databus = rf_rdata;
    else if (src_rd)  databus = rd_data;
  end

  // More than one enabled source is flagged even though the winner drives.
  always_comb begin
    bus_conflict = ($countones(src_vec) > 1);
  end

  // Next-state for the sink registers, PC, ALU flags and sticky error.
  always_comb begin
    ir_d    = ir_en ? databus[31:0] : ir_q;
    a_d     = a_en  ? databus : a_q;
    b_d     = b_en  ? databus : b_q;
    pc_d    = pc_q;
    if (pc_en)       pc_d = databus;
    else if (pc_inc) pc_d = pc_q + XLEN'(4);
    carry_d = alu_wins ? alu_c : carry_q;
    zero_d  = alu_wins ? (alu_res == '0) : zero_q;
    err_d   = err_q | bus_conflict;
  end

  // Register-file write; entry 0 is never written so it always reads zero.
  always_comb begin
    for (int i = 0; i < NREG; i++) rf_d[i] = rf_q[i];
    if (rf_wen && (rf_waddr != '0)) rf_d[rf_waddr] = databus;
  end

  // All state clears asynchronously; sink enables are ignored during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      a_q     <= '0;
      b_q     <= '0;
      ir_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign instr     = ir_q;
  assign pc        = pc_q;
  assign alu_carry = carry_q;
  assign alu_zero  = zero_q;
  assign bus_err   = err_q;

endmodule
